ald_key_conditioner: RTL
========================

Name: ald_key_conditioner

Overview:
- Upstream input stage for the ALD ladder-logic controller on the DE2-115.
- Converts the raw active-low push-buttons (start, stop, tp1..tp3, tr) into debounced active-high levels and scan-aligned press events.
- The rung-scanning controller evaluates one rung per clock, so a 1-cycle pulse could fall between rung evaluations. This block therefore holds each press event for exactly one full rung scan, bounded by the controller's scan-wrap strobe.
- Also enforces stop-over-start priority and flags stuck keys.

Parameters:
- N_CH, 6, number of key channels (bit 0 start, 1 stop, 2 tp1, 3 tp2, 4 tp3, 5 tr).
- DEBOUNCE_CYC, 500000, cycles of stable input required to accept a change (10 ms at 50 MHz); must be ≥ 2.
- STUCK_CYC, 250000000, cycles of continuous debounced press before the stuck flag sets (5 s).
- START_IDX, 0, channel index of start.
- STOP_IDX, 1, channel index of stop.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz, the only clock.
- rst  in  1  reset, synchronous, active-low.
- key_n  in  N_CH  raw asynchronous buttons, 0 = pressed.
- scan_wrap  in  1  1-cycle strobe from the controller when its rung counter wraps to 0.
- level  out  N_CH  debounced key state, 1 = pressed.
- press  out  N_CH  press event, high for exactly one scan period.
- overrun  out  N_CH  sticky: a press was lost because one was already pending.
- stuck  out  N_CH  key held ≥ STUCK_CYC cycles.

Behaviour:
- Reset is sampled only on the CLOCK_50 rising edge while rst = 0. It applies mid-operation as well, discarding pending and active events.
  - Reset values: sync flops = 1 (idle high, so no false press).
  - level, press, pend, overrun, stuck = 0.
  - All counters = 0.
- Synchronizer: 2 flops per channel on key_n, then inverted to give sample (active-high).
- Debounce, per channel, counter width = clog2(DEBOUNCE_CYC):
  - If sample == level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYC-1, level toggles on that edge and the counter clears.
  - Latency from a key_n edge to level = 2 + DEBOUNCE_CYC cycles.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes level.
- Rise detect: rise = level & ~level_q, a 1-cycle internal pulse.
- Event FSM, per channel, states IDLE → PEND → ACTIVE:
  - IDLE: on rise, go to PEND.
  - PEND: on scan_wrap, go to ACTIVE (press = 1 from the next cycle).
  - ACTIVE: on scan_wrap, return to IDLE, or go to PEND if a rise arrived during ACTIVE (press = 0 for at least one cycle).
  - rise in PEND: event dropped, overrun bit sets.
  - rise and scan_wrap in the same cycle while in IDLE: go to PEND and wait for the next wrap. An event never becomes active mid-scan.
  - press == (state == ACTIVE).
- Stop priority:
  - While level[STOP_IDX] = 1, start's FSM is forced to IDLE and press[START_IDX] = 0.
  - A start rise in that window is ignored and does not set overrun.
  - Stop's own channel is unaffected.
- Stuck detect, per channel:
  - Counter increments while level = 1 and saturates at STUCK_CYC.
  - stuck = 1 when the counter == STUCK_CYC.
  - Counter and stuck clear when level returns to 0.
- overrun clears only on reset.
- If scan_wrap never arrives, events remain pending indefinitely. This is permitted behaviour.

Decomposition:
- Shared package ald_pkg holds:
  - channel index constants (CH_START … CH_TR),
  - the event state enum {EV_IDLE, EV_PEND, EV_ACTIVE},
  - the default timing constants.
- One natural sub-module, ald_key_chan: sync + debounce + event FSM + stuck counter for a single channel.
  - Instantiated N_CH times from a generate loop.
  - The top level applies stop priority and concatenates outputs.

Test Plan:
(All scenarios use DEBOUNCE_CYC=4, STUCK_CYC=20, scan_wrap every 8 cycles.)
- Reset: hold rst=0 for 3 cycles with key_n=6'h3F -> all outputs 0. Release -> outputs stay 0 for 100 cycles.
- Clean press: key_n[2] low at t0 -> level[2]=1 at t0+6. press[2] rises the cycle after the next scan_wrap and falls the cycle after the following one (8 cycles wide).
- Glitch: key_n[3] low for 3 cycles -> level[3] and press[3] stay 0.
- Overrun: two debounced rises on ch 4 before one scan_wrap -> one press pulse, overrun[4]=1 and remaining 1 until reset.
- Stop priority: stop held (level[1]=1), then start pressed -> press[0] never asserts and overrun[0]=0. Release stop, press start -> press[0] asserts normally.
- Stuck/mid-reset: hold ch 5 for 30 cycles -> stuck[5]=1 at level-rise+20. Assert rst while press[5]=1 -> next cycle press[5]=0 and stuck[5]=0.

Source files
------------

// File: rtl/ald_pkg.sv
// Shared constants and types for the ALD key conditioner: channel map,
// event state encoding and default timing for a 50 MHz clock.
package ald_pkg;

   localparam int CH_START = 0;
   localparam int CH_STOP  = 1;
   localparam int CH_TP1   = 2;
   localparam int CH_TP2   = 3;
   localparam int CH_TP3   = 4;
   localparam int CH_TR    = 5;
   localparam int N_CH_DEF = 6;

   localparam int DEBOUNCE_CYC_DEF = 500000;
   localparam int STUCK_CYC_DEF    = 250000000;

   typedef enum logic [1:0] {
      EV_IDLE   = 2'd0,
      EV_PEND   = 2'd1,
      EV_ACTIVE = 2'd2
   } ev_state_t;

   // Counter width able to hold values up to n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ald_key_chan.sv
// One key channel: two-flop synchronizer, debounce, scan-aligned press
// event FSM and stuck-key timer.
module ald_key_chan
   import ald_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   parameter int STUCK_CYC    = STUCK_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   input  logic scan_wrap,
   input  logic inhibit,
   output logic level,
   output logic press,
   output logic overrun,
   output logic stuck
);

   localparam int DEB_W = cnt_width(DEBOUNCE_CYC);
   localparam int STK_W = cnt_width(STUCK_CYC + 1);
   localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYC - 1);
   localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_CYC);

   logic             sync1_reg, sync2_reg;
   logic             level_reg, level_next, level_q_reg;
   logic [DEB_W-1:0] deb_cnt_reg, deb_cnt_next;
   ev_state_t        state_reg, state_next;
   logic             again_reg, again_next;
   logic             overrun_reg, overrun_next;
   logic [STK_W-1:0] stuck_cnt_reg, stuck_cnt_next;
   logic             sample, rise;

   assign sample = ~sync2_reg;
   assign rise   = level_reg & ~level_q_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_reg     <= 1'b1;
         sync2_reg     <= 1'b1;
         level_reg     <= 1'b0;
         level_q_reg   <= 1'b0;
         deb_cnt_reg   <= '0;
         state_reg     <= EV_IDLE;
         again_reg     <= 1'b0;
         overrun_reg   <= 1'b0;
         stuck_cnt_reg <= '0;
      end else begin
         sync1_reg     <= key_n;
         sync2_reg     <= sync1_reg;
         level_reg     <= level_next;
         level_q_reg   <= level_reg;
         deb_cnt_reg   <= deb_cnt_next;
         state_reg     <= state_next;
         again_reg     <= again_next;
         overrun_reg   <= overrun_next;
         stuck_cnt_reg <= stuck_cnt_next;
      end
   end

   always_comb begin
      level_next   = level_reg;
      deb_cnt_next = '0;
      if (sample != level_reg) begin
         if (deb_cnt_reg == DEB_MAX) begin
            level_next = ~level_reg;
         end else begin
            deb_cnt_next = deb_cnt_reg + DEB_W'(1);
         end
      end
   end

   // A rise seen while ACTIVE is remembered and re-armed at the wrap, so the
   // controller always sees press drop for at least one cycle between events.
   always_comb begin
      state_next   = state_reg;
      again_next   = again_reg;
      overrun_next = overrun_reg;
      if (inhibit) begin
         state_next = EV_IDLE;
         again_next = 1'b0;
      end else begin
         case (state_reg)
            EV_IDLE: begin
               if (rise) state_next = EV_PEND;
            end
            EV_PEND: begin
               if (rise)      overrun_next = 1'b1;
               if (scan_wrap) state_next   = EV_ACTIVE;
            end
            EV_ACTIVE: begin
               if (rise) begin
                  if (again_reg) overrun_next = 1'b1;
                  again_next = 1'b1;
               end
               if (scan_wrap) begin
                  state_next = (again_reg || rise) ? EV_PEND : EV_IDLE;
                  again_next = 1'b0;
               end
            end
            default: begin
               state_next = EV_IDLE;
               again_next = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      stuck_cnt_next = '0;
      if (level_reg) begin
         stuck_cnt_next = (stuck_cnt_reg == STK_MAX) ? stuck_cnt_reg
                                                     : stuck_cnt_reg + STK_W'(1);
      end
   end

   assign level   = level_reg;
   assign press   = (state_reg == EV_ACTIVE);
   assign overrun = overrun_reg;
   assign stuck   = level_reg && (stuck_cnt_reg == STK_MAX);

endmodule

// File: rtl/ald_key_conditioner.sv
// Key input stage for the ALD ladder controller: per-channel conditioning
// with stop-over-start priority applied across channels.
module ald_key_conditioner
   import ald_pkg::*;
#(
   parameter int N_CH         = N_CH_DEF,
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   parameter int STUCK_CYC    = STUCK_CYC_DEF,
   parameter int START_IDX    = CH_START,
   parameter int STOP_IDX     = CH_STOP
) (
   input  logic            CLOCK_50,
   input  logic            rst,
   input  logic [N_CH-1:0] key_n,
   input  logic            scan_wrap,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] press,
   output logic [N_CH-1:0] overrun,
   output logic [N_CH-1:0] stuck
);

   logic [N_CH-1:0] chan_press;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
         // Only the start channel is held off, and only while stop is down.
         logic hold_off;
         if (gi == START_IDX) begin : g_start
            assign hold_off = level[STOP_IDX];
         end else begin : g_other
            assign hold_off = 1'b0;
         end

         ald_key_chan #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .STUCK_CYC    (STUCK_CYC)
         ) u_chan (
            .clk       (CLOCK_50),
            .rst       (rst),
            .key_n     (key_n[gi]),
            .scan_wrap (scan_wrap),
            .inhibit   (hold_off),
            .level     (level[gi]),
            .press     (chan_press[gi]),
            .overrun   (overrun[gi]),
            .stuck     (stuck[gi])
         );

         assign press[gi] = chan_press[gi] & ~hold_off;
      end
   endgenerate

endmodule
